selftrigger_frame_capture: RTL and testbench
============================================

// Module: selftrigger_frame_capture
// PURPOSE
//  Downstream of the HPF/pedestal-recovery self-trigger stage. Keeps a ring of filtered samples.
//  On a trigger rising edge it freezes PRE_LEN pre-trigger and POST_LEN post-trigger samples,
//  then streams the frame out on a valid/ready port.
//  Frame metadata travels with it: trigger timestamp and baseline latched at the trigger.
//  Triggers arriving while a frame is busy are dropped and counted.
// PARAMETERS
//  PRE_LEN   64   samples before trigger (>=1)
//  POST_LEN  192  samples from trigger cycle onward (>=1)
//  AW        8    ring address width; 2**AW >= PRE_LEN+POST_LEN
// PORTS
//  clk           in   1   sample clock
//  reset         in   1   synchronous, active-low (reset==0 resets)
//  enable        in   1   capture enable; 0 = hold in IDLE
//  x             in   16  signed filtered sample (y of trigger stage)
//  baseline      in   16  signed baseline estimate from trigger stage
//  trigger       in   1   trigger level/pulse from trigger stage
//  timestamp     in   64  free-running time counter
//  out_data      out  16  signed frame sample
//  out_valid     out  1   out_data valid
//  out_ready     in   1   consumer accepts when out_valid&out_ready
//  out_last      out  1   marks final sample of frame
//  out_tstamp    out  64  timestamp at trigger cycle; stable for whole frame
//  out_baseline  out  16  baseline at trigger cycle; stable for whole frame
//  drop_count    out  16  triggers rejected; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE. out_valid=0, out_last=0, out_data=0, out_tstamp=0, out_baseline=0,
//   drop_count=0, write pointer=0, prefill count=0. Ring RAM contents are not cleared.
//  Edge detect: trig_rise = trigger & ~trigger_q. trigger_q resets to 0.
//  IDLE (armed): enable=1 writes x into ring[wp] every cycle, wp++ mod 2**AW.
//   Prefill counter saturates at PRE_LEN.
//   On trig_rise with prefill==PRE_LEN: latch timestamp, baseline; start=wp-PRE_LEN; go POST.
//   The sample of the trigger cycle is written and is frame index PRE_LEN.
//   On trig_rise with prefill<PRE_LEN: ignore; drop_count++.
//  POST: keep writing. After POST_LEN writes (trigger-cycle write included), go READOUT.
//   POST_LEN==1 goes to READOUT on the cycle after the trigger.
//   trig_rise in POST: drop_count++.
//  READOUT: no ring writes. Read address runs start..start+FRAME-1, FRAME=PRE_LEN+POST_LEN.
//   RAM read is 1-cycle; out_valid rises 1 cycle after entering READOUT.
//   Trigger-to-first-valid latency = POST_LEN+1 cycles.
//   out_data/out_last change only on a handshake or when out_valid=0 (no change while stalled).
//   Needs a prefetch/skid register so back-to-back handshakes give 1 sample/cycle.
//   out_last=1 only with frame index FRAME-1.
//   After its handshake: out_valid=0 next cycle; return to IDLE with prefill=0 (ring refills).
//   trig_rise in READOUT: drop_count++.
//  enable=0: IDLE holds, no writes, prefill=0. In POST the frame is aborted (no output),
//   back to IDLE. In READOUT the current frame completes (handshake never truncated).
//  Simultaneous trig_rise and entry to IDLE on the same cycle: counts as dropped
//   (prefill=0 by then).
//  Reset mid-frame: out_valid=0 on the next cycle; partial frame discarded; no out_last.
//  Width: pointer arithmetic is mod 2**AW unsigned. drop_count saturating add.
// STRUCTURE
//  Shared package: state encoding {IDLE,POST,READOUT}; DEFAULT_PRE_LEN, DEFAULT_POST_LEN.
//  One sub-module: selftrigger_ring_ram (simple dual-port, 16b x 2**AW, sync read, 1 write port,
//   1 read port).
//  FSM, pointers, metadata latch and output skid stay in top.
// TESTING
//  Ramp x=0,1,2..; trigger high at sample 100, out_ready=1:
//   -> 256 words 36..291, out_last on 291, out_tstamp=ts@100, first valid at 100+193.
//  Trigger at sample 10 after reset (prefill<64) -> no frame, drop_count=1.
//  out_ready toggling 1/0 every cycle -> same 256 values in order, none repeated or lost,
//   data stable while stalled.
//  Second trigger during POST and another during READOUT -> one frame only, drop_count=2.
//   Next trigger after prefill refilled -> new frame.
//  enable=0 for 5 cycles mid-POST -> no output. Trigger afterwards with prefill met -> clean frame.
//  reset=0 during READOUT at word 50 -> out_valid=0 next cycle, drop_count=0, IDLE.
//   Wrap case: trigger placed so start+FRAME crosses 2**AW -> contiguous ramp output.

Source files
------------

// File: rtl/selftrigger_frame_capture_pkg.sv
// Shared state encoding, default geometry and small arithmetic helpers
// for the self-trigger frame capture block.
package selftrigger_frame_capture_pkg;

    localparam int DEFAULT_PRE_LEN  = 32'd64;
    localparam int DEFAULT_POST_LEN = 32'd192;
    localparam int DEFAULT_AW       = 32'd8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_POST    = 2'd1;
    localparam logic [1:0] ST_READOUT = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/selftrigger_ring_ram.sv
// Simple dual-port sample ring: one write port, one synchronous read port.
// Contents are deliberately not reset.
module selftrigger_ring_ram
    import selftrigger_frame_capture_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    localparam int DEPTH = 32'd1 << AW;

    logic [15:0] mem_r [0:DEPTH-1];

    // Sample write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/selftrigger_frame_capture.sv
// Captures PRE_LEN samples before and POST_LEN samples from a trigger rising edge
// into a ring, then streams the frame with its trigger metadata over valid/ready.
module selftrigger_frame_capture
    import selftrigger_frame_capture_pkg::*;
#(
    parameter int PRE_LEN  = DEFAULT_PRE_LEN,
    parameter int POST_LEN = DEFAULT_POST_LEN,
    parameter int AW       = DEFAULT_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] x,
    input  logic signed [15:0] baseline,
    input  logic               trigger,
    input  logic        [63:0] timestamp,
    output logic signed [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic        [63:0] out_tstamp,
    output logic signed [15:0] out_baseline,
    output logic        [15:0] drop_count
);

    localparam int            FRAME    = PRE_LEN + POST_LEN;
    localparam logic [AW:0]   PRE_CNT  = (AW+1)'(PRE_LEN);
    localparam logic [AW:0]   POST_CNT = (AW+1)'(POST_LEN);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(32'd0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(32'd1);
    localparam logic [AW:0]   RD_INIT  = (AW+1)'(FRAME - 32'sd1);
    localparam logic [AW-1:0] PRE_OFF  = AW'(PRE_LEN);
    localparam logic [AW-1:0] ADDR_ONE = AW'(32'd1);
    localparam logic [AW-1:0] ADDR_ZERO = AW'(32'd0);

    logic [1:0]    state_r;
    logic          trigger_q_r;
    logic [AW-1:0] wp_r;
    logic [AW-1:0] start_r;
    logic [AW-1:0] rd_addr_r;
    logic [AW:0]   prefill_r;
    logic [AW:0]   post_cnt_r;
    logic [AW:0]   rd_left_r;
    logic          rd_pend_r;
    logic          pend_last_r;
    logic          skid_valid_r;
    logic [15:0]   skid_data_r;
    logic          skid_last_r;

    logic [1:0]    state_nxt_s;
    logic          trig_rise_s;
    logic          frame_done_s;
    logic [AW:0]   post_inc_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          first_rd_s;
    logic [AW-1:0] rd_addr_s;
    logic          accept_s;
    logic          drop_s;
    logic          hs_s;
    logic          load_out_s;
    logic          skid_fill_s;
    logic          skid_next_s;
    logic [15:0]   ram_q_s;

    selftrigger_ring_ram #(
        .AW(AW)
    ) u_ring (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wp_r),
        .wdata (x),
        .re    (rd_en_s),
        .raddr (rd_addr_s),
        .rdata (ram_q_s)
    );

    // Output stage: the skid absorbs the in-flight RAM word while the consumer stalls.
    always_comb begin
        hs_s        = out_valid & out_ready;
        load_out_s  = ~out_valid | hs_s;
        skid_fill_s = 1'b0;
        skid_next_s = 1'b0;
        if (load_out_s) begin
            skid_fill_s = skid_valid_r & rd_pend_r;
            skid_next_s = skid_valid_r & rd_pend_r;
        end else begin
            skid_fill_s = rd_pend_r & ~skid_valid_r;
            skid_next_s = skid_valid_r | rd_pend_r;
        end
    end

    // Capture FSM; the first read is issued on the cycle the last post sample is written.
    always_comb begin
        trig_rise_s  = trigger & ~trigger_q_r;
        frame_done_s = hs_s & out_last;
        post_inc_s   = post_cnt_r + CNT_ONE;
        state_nxt_s  = state_r;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        first_rd_s   = 1'b0;
        rd_addr_s    = rd_addr_r;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    wr_en_s = 1'b1;
                    if (trig_rise_s && (prefill_r == PRE_CNT)) begin
                        accept_s = 1'b1;
                        if (POST_CNT == CNT_ONE) begin
                            state_nxt_s = ST_READOUT;
                            rd_en_s     = 1'b1;
                            first_rd_s  = 1'b1;
                            rd_addr_s   = wp_r - PRE_OFF;
                        end else begin
                            state_nxt_s = ST_POST;
                        end
                    end else begin
                        drop_s = trig_rise_s;
                    end
                end else begin
                    drop_s = trig_rise_s;
                end
            end
            ST_POST: begin
                drop_s = trig_rise_s;
                if (enable) begin
                    wr_en_s = 1'b1;
                    if (post_inc_s == POST_CNT) begin
                        state_nxt_s = ST_READOUT;
                        rd_en_s     = 1'b1;
                        first_rd_s  = 1'b1;
                        rd_addr_s   = start_r;
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READOUT: begin
                drop_s = trig_rise_s;
                if ((rd_left_r != CNT_ZERO) && !skid_next_s) begin
                    rd_en_s = 1'b1;
                end else begin
                    rd_en_s = 1'b0;
                end
                if (frame_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READOUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pointers, prefill tracking, metadata latch and drop counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            trigger_q_r  <= 1'b0;
            wp_r         <= ADDR_ZERO;
            start_r      <= ADDR_ZERO;
            rd_addr_r    <= ADDR_ZERO;
            prefill_r    <= CNT_ZERO;
            post_cnt_r   <= CNT_ZERO;
            rd_left_r    <= CNT_ZERO;
            out_tstamp   <= 64'd0;
            out_baseline <= 16'sd0;
            drop_count   <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            trigger_q_r <= trigger;
            if (wr_en_s) begin
                wp_r <= wp_r + ADDR_ONE;
            end
            if ((state_r == ST_IDLE) && enable && !accept_s) begin
                prefill_r <= (prefill_r == PRE_CNT) ? prefill_r : prefill_r + CNT_ONE;
            end else begin
                prefill_r <= CNT_ZERO;
            end
            if (accept_s) begin
                out_tstamp   <= timestamp;
                out_baseline <= baseline;
                start_r      <= wp_r - PRE_OFF;
                post_cnt_r   <= CNT_ONE;
            end else if ((state_r == ST_POST) && wr_en_s) begin
                post_cnt_r <= post_inc_s;
            end
            if (rd_en_s) begin
                rd_addr_r <= rd_addr_s + ADDR_ONE;
                rd_left_r <= first_rd_s ? RD_INIT : rd_left_r - CNT_ONE;
            end
            if (drop_s) begin
                drop_count <= sat_inc16(drop_count);
            end
        end
    end

    // Registered output and skid buffer; output only moves when empty or on a handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pend_r    <= 1'b0;
            pend_last_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 16'd0;
            skid_last_r  <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= 16'sd0;
        end else begin
            rd_pend_r    <= rd_en_s;
            pend_last_r  <= rd_en_s & ~first_rd_s & (rd_left_r == CNT_ONE);
            skid_valid_r <= skid_next_s;
            if (skid_fill_s) begin
                skid_data_r <= ram_q_s;
                skid_last_r <= pend_last_r;
            end
            if (load_out_s) begin
                if (skid_valid_r) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data_r;
                    out_last  <= skid_last_r;
                end else if (rd_pend_r) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_q_s;
                    out_last  <= pend_last_r;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// Directed bench for selftrigger_frame_capture with a scoreboard of expected frame words.
module tb_selftrigger_frame_capture;

    localparam int PRE   = 64;
    localparam int POST  = 192;
    localparam int FRAME = PRE + POST;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [63:0] ts;
        logic [15:0] bl;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [15:0] x;
    logic signed [15:0] baseline;
    logic               trigger;
    logic        [63:0] timestamp;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic        [63:0] out_tstamp;
    logic signed [15:0] out_baseline;
    logic        [15:0] drop_count;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          samp = 0;
    int          cyc = 0;
    int          exp_first = -1;
    int          frame_words = 0;
    int          words_all = 0;
    int          w0;
    bit          rdy_toggle = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] held_data;
    logic        held_last;

    selftrigger_frame_capture dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .x            (x),
        .baseline     (baseline),
        .trigger      (trigger),
        .timestamp    (timestamp),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_tstamp   (out_tstamp),
        .out_baseline (out_baseline),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        x         = 16'(samp);
        timestamp = 64'hABCD_0000_0000_0000 + 64'(cyc);
        baseline  = 16'(cyc * 13 + 7);
    endtask

    // One clock: check outputs at the falling edge, then advance inputs after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid_hold", 64'(out_valid), 64'd1);
            chk("stall_data_hold", {48'd0, out_data}, {48'd0, held_data});
            chk("stall_last_hold", 64'(out_last), 64'(held_last));
        end
        if ((out_valid === 1'b1) && !prev_valid && (exp_first >= 0)) begin
            chk("first_valid_latency", 64'(samp), 64'(exp_first));
            exp_first = -1;
        end
        if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
            frame_words++;
            words_all++;
            chk("word_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", {48'd0, out_data}, {48'd0, e.data});
                chk("out_last", 64'(out_last), 64'(e.last));
                chk("out_tstamp", out_tstamp, e.ts);
                chk("out_baseline", {48'd0, out_baseline}, {48'd0, e.bl});
            end
        end
        prev_valid = out_valid;
        prev_stall = out_valid & ~out_ready;
        held_data  = out_data;
        held_last  = out_last;
        @(posedge clk);
        #1;
        cyc++;
        samp++;
        drive();
        out_ready = rdy_toggle ? ~out_ready : 1'b1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic run_to(input int s);
        for (int i = 0; (i < 20000) && (samp < s); i++) begin
            tick();
        end
    endtask

    task automatic pulse(input bit expect_frame);
        exp_t e;
        trigger = 1'b1;
        if (expect_frame) begin
            for (int i = 0; i < FRAME; i++) begin
                e.data = 16'(samp - PRE + i);
                e.last = (i == FRAME - 1);
                e.ts   = timestamp;
                e.bl   = baseline;
                sb.push_back(e);
            end
            exp_first   = samp + POST + 1;
            frame_words = 0;
        end
        tick();
        trigger = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; (i < 2000) && (sb.size() != 0); i++) begin
            tick();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        wait_n(2);
        chk("valid_low_after_frame", 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        trigger   = 1'b0;
        out_ready = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", {48'd0, out_data}, 64'd0);
        chk("rst_out_tstamp", out_tstamp, 64'd0);
        chk("rst_out_baseline", {48'd0, out_baseline}, 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);

        reset = 1'b1;
        samp  = 0;
        drive();

        // Trigger before the ring holds PRE samples is dropped.
        run_to(10);
        pulse(1'b0);
        wait_n(2);
        chk("drop_prefill_short", 64'(drop_count), 64'd1);

        // Ramp frame 36..291 with ready held high.
        run_to(100);
        pulse(1'b1);
        drain();
        chk("frame1_words", 64'(frame_words), 64'(FRAME));

        // Consumer alternates ready every cycle.
        rdy_toggle = 1'b1;
        wait_n(80);
        pulse(1'b1);
        drain();
        chk("frame_toggle_words", 64'(frame_words), 64'(FRAME));
        rdy_toggle = 1'b0;
        out_ready  = 1'b1;

        // Extra triggers during POST and READOUT are dropped.
        wait_n(80);
        pulse(1'b1);
        wait_n(49);
        pulse(1'b0);
        wait_n(160);
        pulse(1'b0);
        drain();
        chk("frame_busy_words", 64'(frame_words), 64'(FRAME));
        chk("drop_busy", 64'(drop_count), 64'd3);
        wait_n(80);
        pulse(1'b1);
        drain();
        chk("frame_after_busy_words", 64'(frame_words), 64'(FRAME));

        // Disable mid-POST aborts the frame.
        wait_n(80);
        pulse(1'b0);
        wait_n(20);
        enable = 1'b0;
        wait_n(5);
        enable = 1'b1;
        w0 = words_all;
        wait_n(300);
        chk("abort_no_output", 64'(words_all), 64'(w0));
        chk("abort_drop_unchanged", 64'(drop_count), 64'd3);
        pulse(1'b1);
        drain();
        chk("frame_after_abort_words", 64'(frame_words), 64'(FRAME));

        // Reset in the middle of READOUT.
        wait_n(80);
        pulse(1'b1);
        for (int i = 0; (i < 2000) && (frame_words < 50); i++) begin
            tick();
        end
        chk("reached_word50", 64'(frame_words), 64'd50);
        reset = 1'b0;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_last", 64'(out_last), 64'd0);
        chk("midrst_drop_count", 64'(drop_count), 64'd0);
        sb.delete();
        exp_first  = -1;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        reset = 1'b1;
        samp  = 0;
        drive();
        run_to(10);
        pulse(1'b0);
        wait_n(2);
        chk("post_rst_drop", 64'(drop_count), 64'd1);

        // Frame 86..341 wraps the ring address space.
        run_to(150);
        pulse(1'b1);
        drain();
        chk("frame_wrap_words", 64'(frame_words), 64'(FRAME));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
